// File: rtl/bwt_mem_responder_if.sv
// Bus bundle for bwt_mem_responder: request port, memory read channel,
// paired-line response port and the sticky tag error flag.
interface bwt_mem_responder_if #(
    parameter int unsigned READ_NUM_WIDTH = 8
);
    localparam int unsigned ADDR_W = 42;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned TAG_W  = READ_NUM_WIDTH + 1;

    logic                      request_valid;
    logic [READ_NUM_WIDTH-1:0] read_num;
    logic [ADDR_W-1:0]         addr_k;
    logic [ADDR_W-1:0]         addr_l;
    logic                      req_full;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [TAG_W-1:0]          mem_req_tag;

    logic                      mem_rsp_valid;
    logic                      mem_rsp_ready;
    logic [TAG_W-1:0]          mem_rsp_tag;
    logic [LINE_W-1:0]         mem_rsp_data;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [READ_NUM_WIDTH-1:0] rsp_read_num;
    logic [LINE_W-1:0]         rsp_line_k;
    logic [LINE_W-1:0]         rsp_line_l;
    logic                      tag_err;

    // Responder side
    modport slave (
        input  request_valid, read_num, addr_k, addr_l,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
        input  rsp_ready,
        output req_full, mem_req_valid, mem_req_addr, mem_req_tag,
        output mem_rsp_ready, rsp_valid, rsp_read_num, rsp_line_k, rsp_line_l,
        output tag_err
    );

    // Environment side: request source, memory channel and consumer
    modport master (
        output request_valid, read_num, addr_k, addr_l,
        output mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
        output rsp_ready,
        input  req_full, mem_req_valid, mem_req_addr, mem_req_tag,
        input  mem_rsp_ready, rsp_valid, rsp_read_num, rsp_line_k, rsp_line_l,
        input  tag_err
    );
endinterface

// File: rtl/bwt_mem_responder.sv
// bwt_mem_responder: queues (read_num, addr_k, addr_l) requests, issues the k
// and l cache-line reads, pairs the in-order responses and returns them tagged.
// Optional feature macro BWT_SAME_LINE_MERGE_EN: a request whose addr_k equals
// addr_l issues a single read whose line drives both response lines.
module bwt_mem_responder #(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned READ_NUM_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    bwt_mem_responder_if.slave bus
);
    localparam int unsigned ADDR_W = 42;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned TAG_W  = READ_NUM_WIDTH + 1;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned EW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} state_t;

    // request FIFO
    logic [READ_NUM_WIDTH-1:0] fifo_num [DEPTH];
    logic [ADDR_W-1:0]         fifo_k   [DEPTH];
    logic [ADDR_W-1:0]         fifo_l   [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr, rd_ptr_nx;
    logic [CW-1:0]             req_count, req_count_nx;
    logic                      push, pop, same_line, req_full;

    // issue side
    state_t                    state;
    logic                      mem_req_valid, req_fire, can_issue;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [TAG_W-1:0]          mem_req_tag;

    // expected-tag FIFO; its occupancy is the outstanding-read count
    logic [TAG_W-1:0]          exp_tag  [MAX_OUTSTANDING];
    logic                      exp_last [MAX_OUTSTANDING];
    logic [EW-1:0]             exp_wr, exp_rd;
    logic [OW-1:0]             exp_count, outstanding_nx;
    logic                      exp_pop, exp_empty, head_last;
    logic [TAG_W-1:0]          head_tag;

    // pair stage
    logic                      alive, rsp_fire, mem_rsp_ready;
    logic                      rsp_valid, tag_err;
    logic [READ_NUM_WIDTH-1:0] rsp_read_num;
    logic [LINE_W-1:0]         line_k_hold, rsp_line_k, rsp_line_l;

    function automatic logic [EW-1:0] exp_inc(input logic [EW-1:0] p);
        return (p == EW'(MAX_OUTSTANDING - 1)) ? '0 : p + EW'(1);
    endfunction

`ifdef BWT_SAME_LINE_MERGE_EN
    assign same_line = (fifo_k[rd_ptr] == fifo_l[rd_ptr]);
`else
    assign same_line = 1'b0;
`endif

    assign req_fire       = mem_req_valid && bus.mem_req_ready;
    assign pop            = req_fire && ((state == ISSUE_L) || ((state == ISSUE_K) && same_line));
    assign push           = bus.request_valid && ((req_count != CW'(DEPTH)) || pop);
    assign rd_ptr_nx      = rd_ptr + AW'(1);
    assign req_count_nx   = req_count + CW'(push) - CW'(pop);

    assign exp_empty      = (exp_count == '0);
    assign head_tag       = exp_tag[exp_rd];
    assign head_last      = exp_last[exp_rd];
    assign rsp_fire       = bus.mem_rsp_valid && mem_rsp_ready;
    assign exp_pop        = rsp_fire && !exp_empty;
    assign outstanding_nx = exp_count + OW'(req_fire) - OW'(exp_pop);
    assign can_issue      = (outstanding_nx < OW'(MAX_OUTSTANDING));

    // Stall only a response that would overwrite a pair the consumer has not taken.
    assign mem_rsp_ready  = alive && !(!exp_empty && head_last && rsp_valid && !bus.rsp_ready);

    assign bus.req_full      = req_full;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_addr  = mem_req_addr;
    assign bus.mem_req_tag   = mem_req_tag;
    assign bus.mem_rsp_ready = mem_rsp_ready;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_read_num  = rsp_read_num;
    assign bus.rsp_line_k    = rsp_line_k;
    assign bus.rsp_line_l    = rsp_line_l;
    assign bus.tag_err       = tag_err;

    // Request FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_num[wr_ptr] <= bus.read_num;
            fifo_k[wr_ptr]   <= bus.addr_k;
            fifo_l[wr_ptr]   <= bus.addr_l;
        end
    end

    // Request FIFO pointers, occupancy and early-full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            req_count <= '0;
            req_full  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_nx;
            req_count <= req_count_nx;
            req_full  <= (req_count_nx >= CW'(DEPTH - 1));
        end
    end

    // Issue FSM: k read then l read per request, throttled by outstanding reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_count != '0) begin
                        state         <= ISSUE_K;
                        mem_req_valid <= can_issue;
                        mem_req_addr  <= fifo_k[rd_ptr];
                        mem_req_tag   <= {fifo_num[rd_ptr], 1'b0};
                    end
                end
                ISSUE_K, ISSUE_L: begin
                    if (pop) begin
                        // Only entries already stored behind the head may be issued next.
                        if (req_count > CW'(1)) begin
                            state         <= ISSUE_K;
                            mem_req_valid <= can_issue;
                            mem_req_addr  <= fifo_k[rd_ptr_nx];
                            mem_req_tag   <= {fifo_num[rd_ptr_nx], 1'b0};
                        end else begin
                            state         <= IDLE;
                            mem_req_valid <= 1'b0;
                        end
                    end else if (req_fire) begin
                        state         <= ISSUE_L;
                        mem_req_valid <= can_issue;
                        mem_req_addr  <= fifo_l[rd_ptr];
                        mem_req_tag   <= {fifo_num[rd_ptr], 1'b1};
                    end else begin
                        mem_req_valid <= can_issue;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Expected-tag FIFO storage; last marks the read that completes a pair
    always_ff @(posedge clk) begin
        if (req_fire) begin
            exp_tag[exp_wr]  <= mem_req_tag;
            exp_last[exp_wr] <= pop;
        end
    end

    // Expected-tag FIFO pointers and outstanding count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_wr    <= '0;
            exp_rd    <= '0;
            exp_count <= '0;
        end else begin
            if (req_fire) exp_wr <= exp_inc(exp_wr);
            if (exp_pop)  exp_rd <= exp_inc(exp_rd);
            exp_count <= outstanding_nx;
        end
    end

    // Pair stage: hold the k line, emit the pair on the completing response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive        <= 1'b0;
            line_k_hold  <= '0;
            rsp_valid    <= 1'b0;
            rsp_read_num <= '0;
            rsp_line_k   <= '0;
            rsp_line_l   <= '0;
            tag_err      <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (exp_pop && (bus.mem_rsp_tag != head_tag)) tag_err <= 1'b1;
            if (exp_pop && !head_last) line_k_hold <= bus.mem_rsp_data;
            if (exp_pop && head_last) begin
                rsp_valid    <= 1'b1;
                rsp_read_num <= head_tag[TAG_W-1:1];
                // A completing read with sel=0 is a merged single-line request.
                rsp_line_k   <= head_tag[0] ? line_k_hold : bus.mem_rsp_data;
                rsp_line_l   <= bus.mem_rsp_data;
            end else if (bus.rsp_ready) begin
                rsp_valid    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bwt_mem_responder.sv
// Directed bench for bwt_mem_responder: single pair, backpressure on both
// sides, same-line request, tag mismatch and reset with reads in flight.
module tb_bwt_mem_responder;
    localparam int unsigned RNW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bwt_mem_responder_if #(.READ_NUM_WIDTH(RNW)) bus ();

    bwt_mem_responder #(
        .DEPTH(8), .MAX_OUTSTANDING(4), .READ_NUM_WIDTH(RNW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int rsp_idx  = 0;

    logic [41:0]  iss_addr [$];
    logic [8:0]   iss_tag  [$];
    logic [7:0]   out_num  [$];
    logic [511:0] out_k    [$];
    logic [511:0] out_l    [$];

    function automatic logic [511:0] line_of(input logic [41:0] a);
        return {8{22'h2A5A5, a}};
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Record memory request and pair handshakes
    always @(posedge clk) begin
        if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
            iss_addr.push_back(bus.mem_req_addr);
            iss_tag.push_back(bus.mem_req_tag);
        end
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            out_num.push_back(bus.rsp_read_num);
            out_k.push_back(bus.rsp_line_k);
            out_l.push_back(bus.rsp_line_l);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.request_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.rsp_ready     = 1'b0;
        #1;
        check("rst_ctl", 512'({bus.req_full, bus.mem_req_valid, bus.mem_rsp_ready, bus.rsp_valid, bus.tag_err}), 512'(0));
        check("rst_addr_tag", 512'({bus.mem_req_addr, bus.mem_req_tag, bus.rsp_read_num}), 512'(0));
        check("rst_lines", bus.rsp_line_k | bus.rsp_line_l, 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        iss_addr.delete(); iss_tag.delete();
        out_num.delete(); out_k.delete(); out_l.delete();
        rsp_idx = 0;
        @(negedge clk);
        check("post_rst_mem_rsp_ready", 512'(bus.mem_rsp_ready), 512'(1));
    endtask

    task automatic push_req(input logic [7:0] num, input logic [41:0] ak, input logic [41:0] al);
        @(negedge clk);
        bus.request_valid = 1'b1;
        bus.read_num = num; bus.addr_k = ak; bus.addr_l = al;
        @(negedge clk);
        bus.request_valid = 1'b0;
    endtask

    task automatic wait_issued(input int n, input string tag);
        int cyc = 0;
        while (iss_addr.size() < n && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 512'(iss_addr.size() >= n), 512'(1));
    endtask

    task automatic respond(input logic [8:0] tag, input logic [511:0] data);
        bit done = 1'b0;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = tag;
        bus.mem_rsp_data  = data;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            done = bus.mem_rsp_ready;
        end
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("mem_rsp_accept", 512'(done), 512'(1));
    endtask

    // Answer the oldest unanswered memory read with its line
    task automatic respond_next();
        int cyc = 0;
        while (rsp_idx >= iss_addr.size() && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("issue_avail", 512'(rsp_idx < iss_addr.size()), 512'(1));
        if (rsp_idx < iss_addr.size()) begin
            respond(iss_tag[rsp_idx], line_of(iss_addr[rsp_idx]));
            rsp_idx++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.request_valid = 1'b0; bus.read_num = '0; bus.addr_k = '0; bus.addr_l = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = '0;
        bus.mem_rsp_data = '0; bus.rsp_ready = 1'b0;

        // Single request, pair returned one cycle after the second response
        apply_reset();
        bus.mem_req_ready = 1'b1;
        push_req(8'd5, 42'h100, 42'h200);
        wait_issued(2, "t1_issue");
        check("t1_k_addr", 512'(iss_addr[0]), 512'(42'h100));
        check("t1_k_tag",  512'(iss_tag[0]),  512'({8'd5, 1'b0}));
        check("t1_l_addr", 512'(iss_addr[1]), 512'(42'h200));
        check("t1_l_tag",  512'(iss_tag[1]),  512'({8'd5, 1'b1}));
        respond({8'd5, 1'b0}, {64{8'hAA}});
        check("t1_no_pair_yet", 512'(bus.rsp_valid), 512'(0));
        respond({8'd5, 1'b1}, {64{8'hBB}});
        check("t1_rsp_valid", 512'(bus.rsp_valid), 512'(1));
        check("t1_read_num", 512'(bus.rsp_read_num), 512'(5));
        check("t1_line_k", bus.rsp_line_k, {64{8'hAA}});
        check("t1_line_l", bus.rsp_line_l, {64{8'hBB}});
        check("t1_tag_err", 512'(bus.tag_err), 512'(0));
        consume();
        check("t1_rsp_cleared", 512'(bus.rsp_valid), 512'(0));
        check("t1_consumed", 512'(out_num.size()), 512'(1));

        // Eight back-to-back requests: early full, outstanding limit, no drops
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 6) check("t2_not_full_at6", 512'(bus.req_full), 512'(0));
            if (i == 7) check("t2_full_at7", 512'(bus.req_full), 512'(1));
            bus.request_valid = 1'b1;
            bus.read_num = 8'(10 + i);
            bus.addr_k = 42'h1000 + 42'(i);
            bus.addr_l = 42'h2000 + 42'(i);
        end
        @(negedge clk);
        bus.request_valid = 1'b0;
        check("t2_full_at8", 512'(bus.req_full), 512'(1));
        check("t2_valid_held", 512'(bus.mem_req_valid), 512'(1));
        check("t2_addr_held", 512'(bus.mem_req_addr), 512'(42'h1000));
        bus.mem_req_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("t2_issued_max", 512'(iss_addr.size()), 512'(4));
        check("t2_valid_blocked", 512'(bus.mem_req_valid), 512'(0));
        check("t2_next_addr", 512'(bus.mem_req_addr), 512'(42'h1002));
        for (int cyc = 0; cyc < 300 && out_num.size() < 8; cyc++) begin
            if (rsp_idx < iss_addr.size()) respond_next();
            else @(negedge clk);
        end
        check("t2_pairs", 512'(out_num.size()), 512'(8));
        check("t2_reads", 512'(iss_addr.size()), 512'(16));
        for (int i = 0; i < 8 && i < out_num.size(); i++) begin
            check("t2_num", 512'(out_num[i]), 512'(10 + i));
            check("t2_k", out_k[i], line_of(42'h1000 + 42'(i)));
            check("t2_l", out_l[i], line_of(42'h2000 + 42'(i)));
        end

        // Consumer stall blocks only the pair-completing response
        apply_reset();
        bus.mem_req_ready = 1'b1;
        push_req(8'd1, 42'h10, 42'h20);
        push_req(8'd2, 42'h30, 42'h40);
        wait_issued(4, "t3_issue");
        respond_next();
        respond_next();
        check("t3_pair1_valid", 512'(bus.rsp_valid), 512'(1));
        respond_next();
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = {8'd2, 1'b1};
        bus.mem_rsp_data  = line_of(42'h40);
        #1;
        check("t3_stall", 512'(bus.mem_rsp_ready), 512'(0));
        repeat (3) @(negedge clk);
        check("t3_stall_held", 512'(bus.mem_rsp_ready), 512'(0));
        check("t3_pair1_num", 512'(bus.rsp_read_num), 512'(1));
        bus.rsp_ready = 1'b1;
        #1;
        check("t3_release", 512'(bus.mem_rsp_ready), 512'(1));
        @(negedge clk);
        bus.rsp_ready     = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        check("t3_pair2_valid", 512'(bus.rsp_valid), 512'(1));
        check("t3_pair2_num", 512'(bus.rsp_read_num), 512'(2));
        check("t3_pair2_k", bus.rsp_line_k, line_of(42'h30));
        check("t3_pair2_l", bus.rsp_line_l, line_of(42'h40));
        check("t3_pair1_taken", 512'(out_num.size()), 512'(1));
        check("t3_pair1_k", out_k[0], line_of(42'h10));
        check("t3_pair1_l", out_l[0], line_of(42'h20));
        consume();
        check("t3_drained", 512'(bus.rsp_valid), 512'(0));

        // Same line for k and l
        apply_reset();
        bus.mem_req_ready = 1'b1;
        push_req(8'd9, 42'h300, 42'h300);
`ifdef BWT_SAME_LINE_MERGE_EN
        wait_issued(1, "t4_issue");
        repeat (5) @(negedge clk);
        check("t4_one_read", 512'(iss_addr.size()), 512'(1));
        check("t4_tag", 512'(iss_tag[0]), 512'({8'd9, 1'b0}));
        respond_next();
`else
        wait_issued(2, "t4_issue");
        check("t4_tag_k", 512'(iss_tag[0]), 512'({8'd9, 1'b0}));
        check("t4_tag_l", 512'(iss_tag[1]), 512'({8'd9, 1'b1}));
        check("t4_addr_l", 512'(iss_addr[1]), 512'(42'h300));
        respond_next();
        respond_next();
`endif
        check("t4_valid", 512'(bus.rsp_valid), 512'(1));
        check("t4_num", 512'(bus.rsp_read_num), 512'(9));
        check("t4_k", bus.rsp_line_k, line_of(42'h300));
        check("t4_l", bus.rsp_line_l, line_of(42'h300));
        consume();

        // Tag mismatch is sticky; data still used
        apply_reset();
        bus.mem_req_ready = 1'b1;
        push_req(8'd7, 42'h700, 42'h780);
        wait_issued(2, "t5_issue");
        check("t5_err_clear", 512'(bus.tag_err), 512'(0));
        respond({8'd7, 1'b1}, line_of(42'h700));
        check("t5_err_set", 512'(bus.tag_err), 512'(1));
        respond({8'd7, 1'b1}, line_of(42'h780));
        check("t5_pair_num", 512'(bus.rsp_read_num), 512'(7));
        check("t5_pair_k", bus.rsp_line_k, line_of(42'h700));
        consume();
        repeat (3) @(negedge clk);
        check("t5_err_sticky", 512'(bus.tag_err), 512'(1));

        // Reset with three reads outstanding, late response dropped, then recovery
        push_req(8'd3, 42'h500, 42'h540);
        push_req(8'd4, 42'h580, 42'h5C0);
        wait_issued(6, "t6_issue");
        rsp_idx = 2;
        respond_next();
        apply_reset();
        respond({8'd4, 1'b1}, {512{1'b1}});
        check("t6_late_no_pair", 512'(bus.rsp_valid), 512'(0));
        check("t6_late_no_err", 512'(bus.tag_err), 512'(0));
        check("t6_no_issue", 512'(bus.mem_req_valid), 512'(0));
        bus.mem_req_ready = 1'b1;
        push_req(8'd6, 42'h600, 42'h640);
        wait_issued(2, "t6_reissue");
        check("t6_k_addr", 512'(iss_addr[0]), 512'(42'h600));
        respond_next();
        respond_next();
        check("t6_valid", 512'(bus.rsp_valid), 512'(1));
        check("t6_num", 512'(bus.rsp_read_num), 512'(6));
        check("t6_k", bus.rsp_line_k, line_of(42'h600));
        check("t6_l", bus.rsp_line_l, line_of(42'h640));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
